pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Game sequencer for the 8x8 LED Pong display.
- Generates the ball position, paddle positions and `playing` flag consumed by the matrix drawing block.
- Runs the serve/play/point/game-over state machine, paddle movement, wall bounce, paddle collision and scoring, all at a prescaled game tick.
- Outputs change on posedge clk only, so they are stable when the drawing block samples on negedge.

Parameters:
- TICK_DIV, 2500000, clk cycles per game tick (>=2).
- SERVE_WAIT, 4, ticks spent in SERVE and in POINT (>=1).
- WIN_SCORE, 5, points needed to win (1..7).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  level; begins a new game from IDLE or OVER
- btnA_l  in  1  paddle A left; synchronised/debounced upstream
- btnA_r  in  1  paddle A right
- btnB_l  in  1  paddle B left
- btnB_r  in  1  paddle B right
- ballX  out  3  ball column
- ballY  out  3  ball row; row 0 = paddle A, row 7 = paddle B
- padA  out  3  paddle A centre column, range 1..6
- padB  out  3  paddle B centre column, range 1..6
- playing  out  1  1 in SERVE/PLAY/POINT, 0 in IDLE/OVER
- scoreA  out  3  points for A
- scoreB  out  3  points for B
- winner  out  2  00 none, 01 A, 10 B

Behaviour:

Reset (rst=1 at posedge):
- State IDLE, prescaler=0.
- ballX=3, ballY=3, padA=padB=3.
- scoreA=scoreB=0, winner=00, playing=0.
- Internal dx=+1, dy=+1.
- rst overrides everything, including mid-PLAY.

Tick prescaler:
- Free-running, counts 0..TICK_DIV-1.
- `tick` = 1 on the cycle where count==TICK_DIV-1.
- All motion updates only on tick cycles.

Paddles (on tick, in SERVE/PLAY/POINT):
- L only: decrement if >1.
- R only: increment if <6.
- Both or neither: hold.
- Frozen in IDLE/OVER.

States:
- IDLE:
  - start=1 (any cycle, not tick-gated) → SERVE.
  - Scores cleared; ball at (3,3); pads at 3; dx=+1, dy=+1; wait counter=0.
- SERVE:
  - Ball stationary.
  - On each tick, wait counter +1; when it reaches SERVE_WAIT → PLAY, counter cleared.
- PLAY, each tick, using pre-tick ball, dx, dy and paddle values:
  - X step: x==7 and dx=+1 → dx=-1, nx=6. x==0 and dx=-1 → dx=+1, nx=1. Otherwise nx=x+dx.
  - Y toward A (dy=-1, y==1):
    - Hit if |nx-padA|<=1: dy=+1, ny=2.
    - Miss: ny=0, scoreB+1, → POINT, next serve dy=-1.
  - Y toward B (dy=+1, y==6):
    - Hit if |nx-padB|<=1: dy=-1, ny=5.
    - Miss: ny=7, scoreA+1, → POINT, next serve dy=+1.
  - Otherwise ny=y+dy.
- POINT:
  - Ball held at the miss position for SERVE_WAIT ticks.
  - Then, if scoreA==WIN_SCORE → OVER with winner=01; if scoreB==WIN_SCORE → OVER with winner=10.
  - Else → SERVE: ball (3,3), dx inverted from the previous serve, dy as recorded at the miss.
- OVER:
  - playing=0; ball, pads, scores and winner held.
  - start=1 → same action as from IDLE; winner cleared.

Width rules and other boundaries:
- Ball coordinates are 3-bit and never wrap; the reflection rules keep them in 0..7.
- `start` is ignored in SERVE/PLAY/POINT.
- A tick that coincides with a state change from start does not also move anything.

Test Plan:
- Reset: assert rst for 2 cycles → ballX=3, ballY=3, padA=padB=3, scores 0, winner=00, playing=0; hold start=0 for 20 cycles → no change.
- Miss at B (TICK_DIV=4, SERVE_WAIT=2, WIN_SCORE=5, no buttons): start pulse → playing=1. PLAY entered after 2 ticks. Ball then goes (4,4),(5,5),(6,6),(7,7). At (7,7) state=POINT, scoreA=1; after 2 more ticks ball returns to (3,3) in SERVE.
- Hit at B: as above, but hold btnB_r from the first PLAY tick. padB goes 4,5,6. Tick 4 → ball (7,5) with hit, dy=-1. Next tick → ball (6,4) with wall bounce. scoreA stays 0.
- Paddle clamp: during SERVE with SERVE_WAIT=8, hold btnA_l for 5 ticks → padA 2,1,1,1,1. Hold btnA_l and btnA_r together → padA unchanged.
- Game over (WIN_SCORE=2, no buttons):
  - Second serve uses dx=-1: ball (2,4),(1,5),(0,6), then (1,7) miss.
  - After POINT wait → OVER, playing=0, winner=01, scoreA=2.
  - start=1 → SERVE, scores 0, winner=00.
- Reset mid-PLAY: assert rst while ball is at (5,5) → next edge gives all reset values and IDLE; prescaler restarts from 0.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
// Game sequencer for the 8x8 LED Pong display. Runs the
// IDLE/SERVE/PLAY/POINT/OVER state machine. It also handles paddle movement,
// wall bounce, paddle collision and scoring, all at a prescaled game tick.
// Every output is registered on posedge clk, so the matrix drawing block can
// sample it safely on negedge.
//
// Parameters
//   TICK_DIV   clk cycles per game tick (>=2)
//   SERVE_WAIT ticks spent in SERVE and in POINT (>=1)
//   WIN_SCORE  points needed to win (1..7)
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   start          level; begins a new game from IDLE or OVER
//   btnA_l/btnA_r  paddle A left/right (already synchronised/debounced)
//   btnB_l/btnB_r  paddle B left/right
//   ballX, ballY   ball column/row (row 0 = paddle A, row 7 = paddle B)
//   padA, padB     paddle centre columns, 1..6
//   playing        1 in SERVE/PLAY/POINT
//   scoreA/scoreB  points per player
//   winner         00 none, 01 A, 10 B
// ---------------------------------------------------------------------------
module pong_game_ctrl #(
    parameter int TICK_DIV   = 2500000,
    parameter int SERVE_WAIT = 4,
    parameter int WIN_SCORE  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       btnA_l,
    input  logic       btnA_r,
    input  logic       btnB_l,
    input  logic       btnB_r,
    output logic [2:0] ballX,
    output logic [2:0] ballY,
    output logic [2:0] padA,
    output logic [2:0] padB,
    output logic       playing,
    output logic [2:0] scoreA,
    output logic [2:0] scoreB,
    output logic [1:0] winner
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int WAIT_W = (SERVE_WAIT < 2) ? 1 : $clog2(SERVE_WAIT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SERVE_WAIT - 1);
    localparam logic [2:0]        WIN       = 3'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_POINT,
        S_OVER
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  cnt;
    logic              tick;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_done;
    logic              dx_pos;     // 1: ball moving toward column 7
    logic              dy_pos;     // 1: ball moving toward row 7 (paddle B)
    logic              serve_dx;   // horizontal direction used at the last serve
    logic              game_won;

    // Next ball position and direction for a PLAY tick
    logic [2:0] nx, ny;
    logic       nx_dx, ny_dy;
    logic       miss_a, miss_b;

    // Paddle step with clamping to 1..6; both buttons or none holds.
    function automatic logic [2:0] pad_step(input logic [2:0] pad,
                                            input logic l, input logic r);
        if (l && !r && pad > 3'd1)
            return pad - 3'd1;
        else if (r && !l && pad < 3'd6)
            return pad + 3'd1;
        else
            return pad;
    endfunction

    // True when the ball column is within one column of the paddle centre.
    function automatic logic near(input logic [2:0] col, input logic [2:0] pad);
        logic signed [3:0] d;
        d = signed'({1'b0, col}) - signed'({1'b0, pad});
        return (d >= -4'sd1) && (d <= 4'sd1);
    endfunction

    // ---- game tick prescaler ----
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick      = (cnt == CNT_LAST);
    assign wait_done = tick && (wait_cnt == WAIT_LAST);
    assign game_won  = (scoreA == WIN) || (scoreB == WIN);

    // ---- ball step: wall bounce in X, paddle hit or miss in Y ----
    always_comb begin
        nx     = ballX;
        nx_dx  = dx_pos;
        ny     = ballY;
        ny_dy  = dy_pos;
        miss_a = 1'b0;
        miss_b = 1'b0;

        if (ballX == 3'd7 && dx_pos) begin
            nx    = 3'd6;
            nx_dx = 1'b0;
        end else if (ballX == 3'd0 && !dx_pos) begin
            nx    = 3'd1;
            nx_dx = 1'b1;
        end else begin
            nx = dx_pos ? ballX + 3'd1 : ballX - 3'd1;
        end

        // Collision uses the new column against the pre-tick paddle position.
        if (!dy_pos && ballY == 3'd1) begin
            if (near(nx, padA)) begin
                ny    = 3'd2;
                ny_dy = 1'b1;
            end else begin
                ny     = 3'd0;
                miss_a = 1'b1;
            end
        end else if (dy_pos && ballY == 3'd6) begin
            if (near(nx, padB)) begin
                ny    = 3'd5;
                ny_dy = 1'b0;
            end else begin
                ny     = 3'd7;
                miss_b = 1'b1;
            end
        end else begin
            ny = dy_pos ? ballY + 3'd1 : ballY - 3'd1;
        end
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_OVER: if (start)                        state_next = S_SERVE;
            S_SERVE:        if (wait_done)                    state_next = S_PLAY;
            S_PLAY:         if (tick && (miss_a || miss_b))   state_next = S_POINT;
            S_POINT:        if (wait_done)                    state_next = game_won ? S_OVER : S_SERVE;
            default:                                          state_next = S_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        playing = (state == S_SERVE) || (state == S_PLAY) || (state == S_POINT);
    end

    // ---- ball, paddle, score and serve bookkeeping ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ballX    <= 3'd3;
            ballY    <= 3'd3;
            padA     <= 3'd3;
            padB     <= 3'd3;
            scoreA   <= 3'd0;
            scoreB   <= 3'd0;
            winner   <= 2'b00;
            dx_pos   <= 1'b1;
            dy_pos   <= 1'b1;
            serve_dx <= 1'b1;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_OVER: begin
                    // Start wins over a coincident tick: nothing moves here.
                    if (start) begin
                        ballX    <= 3'd3;
                        ballY    <= 3'd3;
                        padA     <= 3'd3;
                        padB     <= 3'd3;
                        scoreA   <= 3'd0;
                        scoreB   <= 3'd0;
                        winner   <= 2'b00;
                        dx_pos   <= 1'b1;
                        dy_pos   <= 1'b1;
                        serve_dx <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                S_SERVE: begin
                    if (tick) begin
                        padA     <= pad_step(padA, btnA_l, btnA_r);
                        padB     <= pad_step(padB, btnB_l, btnB_r);
                        wait_cnt <= wait_done ? '0 : wait_cnt + 1'b1;
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        padA   <= pad_step(padA, btnA_l, btnA_r);
                        padB   <= pad_step(padB, btnB_l, btnB_r);
                        ballX  <= nx;
                        ballY  <= ny;
                        dx_pos <= nx_dx;
                        dy_pos <= ny_dy;
                        // dy left at the miss value becomes the next serve's dy.
                        if (miss_a) scoreB <= scoreB + 3'd1;
                        if (miss_b) scoreA <= scoreA + 3'd1;
                    end
                end
                S_POINT: begin
                    if (tick) begin
                        padA <= pad_step(padA, btnA_l, btnA_r);
                        padB <= pad_step(padB, btnB_l, btnB_r);
                        if (wait_done) begin
                            wait_cnt <= '0;
                            if (scoreA == WIN) begin
                                winner <= 2'b01;
                            end else if (scoreB == WIN) begin
                                winner <= 2'b10;
                            end else begin
                                // Alternate the horizontal serve direction.
                                ballX    <= 3'd3;
                                ballY    <= 3'd3;
                                dx_pos   <= ~serve_dx;
                                serve_dx <= ~serve_dx;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pong_game_ctrl
// Directed bench for pong_game_ctrl. The main instance runs TICK_DIV=4,
// SERVE_WAIT=2, WIN_SCORE=2. A second instance with SERVE_WAIT=8 and
// WIN_SCORE=5 shares the inputs and is used for the paddle clamp sequence.
// ---------------------------------------------------------------------------
module tb_pong_game_ctrl;

    localparam int TD = 4;

    logic       clk, rst, start;
    logic       btnA_l, btnA_r, btnB_l, btnB_r;
    logic [2:0] ballX, ballY, padA, padB, scoreA, scoreB;
    logic       playing;
    logic [1:0] winner;

    logic [2:0] ballX2, ballY2, padA2, padB2, scoreA2, scoreB2;
    logic       playing2;
    logic [1:0] winner2;

    int n_vec = 0;
    int n_err = 0;
    int tcnt  = 0;   // expected prescaler value after the last edge

    pong_game_ctrl #(.TICK_DIV(TD), .SERVE_WAIT(2), .WIN_SCORE(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .btnA_l(btnA_l), .btnA_r(btnA_r), .btnB_l(btnB_l), .btnB_r(btnB_r),
        .ballX(ballX), .ballY(ballY), .padA(padA), .padB(padB),
        .playing(playing), .scoreA(scoreA), .scoreB(scoreB), .winner(winner)
    );

    pong_game_ctrl #(.TICK_DIV(TD), .SERVE_WAIT(8), .WIN_SCORE(5)) dut2 (
        .clk(clk), .rst(rst), .start(start),
        .btnA_l(btnA_l), .btnA_r(btnA_r), .btnB_l(btnB_l), .btnB_r(btnB_r),
        .ballX(ballX2), .ballY(ballY2), .padA(padA2), .padB(padB2),
        .playing(playing2), .scoreA(scoreA2), .scoreB(scoreB2), .winner(winner2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ball(input string tag, input int x, input int y);
        chk({tag, "_x"}, ballX, x);
        chk({tag, "_y"}, ballY, y);
    endtask

    task automatic chk_reset(input string tag);
        chk_ball(tag, 3, 3);
        chk({tag, "_padA"},    padA, 3);
        chk({tag, "_padB"},    padB, 3);
        chk({tag, "_scoreA"},  scoreA, 0);
        chk({tag, "_scoreB"},  scoreB, 0);
        chk({tag, "_winner"},  winner, 0);
        chk({tag, "_playing"}, playing, 0);
    endtask

    // One clock edge; outputs are read 1 time unit after it.
    task automatic step();
        @(posedge clk);
        if (rst) tcnt = 0;
        else     tcnt = (tcnt == TD - 1) ? 0 : tcnt + 1;
        #1;
    endtask

    // Advance through the next edge on which the game tick is active.
    task automatic next_tick();
        bit was;
        for (int g = 0; g < TD; g++) begin
            was = (tcnt == TD - 1);
            step();
            if (was) return;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0;
        btnA_l = 1'b0; btnA_r = 1'b0; btnB_l = 1'b0; btnB_r = 1'b0;

        // Reset and idle hold
        step(); step();
        chk_reset("rst");
        rst = 1'b0;
        repeat (20) step();
        chk_reset("idle");

        // Game 1: miss at B
        start = 1'b1; step(); start = 1'b0;
        chk("g1_playing", playing, 1);
        chk_ball("g1_serve0", 3, 3);
        next_tick(); chk_ball("g1_serve1", 3, 3);
        next_tick(); chk_ball("g1_serve2", 3, 3);
        for (int i = 1; i <= 4; i++) begin
            next_tick(); chk_ball("g1_play", 3 + i, 3 + i);
        end
        chk("g1_scoreA", scoreA, 1);
        chk("g1_scoreB", scoreB, 0);
        chk("g1_point_playing", playing, 1);
        next_tick(); chk_ball("g1_point_hold", 7, 7);
        next_tick(); chk_ball("g1_reserve", 3, 3);

        // Second serve goes left, miss at B again ends the game
        next_tick(); next_tick(); chk_ball("g2_serve", 3, 3);
        next_tick(); chk_ball("g2_t1", 2, 4);
        next_tick(); chk_ball("g2_t2", 1, 5);
        next_tick(); chk_ball("g2_t3", 0, 6);
        next_tick(); chk_ball("g2_t4", 1, 7);
        chk("g2_scoreA", scoreA, 2);
        next_tick(); chk("g2_point_playing", playing, 1);
        next_tick();
        chk("over_playing", playing, 0);
        chk("over_winner", winner, 1);
        chk("over_scoreA", scoreA, 2);
        chk_ball("over_ball", 1, 7);
        repeat (3) next_tick();
        chk_ball("over_hold", 1, 7);
        chk("over_hold_winner", winner, 1);

        // Restart from OVER, then paddle B hit
        start = 1'b1; step(); start = 1'b0;
        chk("rs_playing", playing, 1);
        chk("rs_scoreA", scoreA, 0);
        chk("rs_winner", winner, 0);
        chk_ball("rs_ball", 3, 3);
        next_tick(); next_tick();
        btnB_r = 1'b1;
        next_tick(); chk_ball("hb_t1", 4, 4); chk("hb_padB1", padB, 4);
        next_tick(); chk_ball("hb_t2", 5, 5); chk("hb_padB2", padB, 5);
        next_tick(); chk_ball("hb_t3", 6, 6); chk("hb_padB3", padB, 6);
        next_tick(); chk_ball("hb_hit", 7, 5); chk("hb_padB4", padB, 6);
        next_tick(); chk_ball("hb_wall", 6, 4);
        chk("hb_scoreA", scoreA, 0);
        next_tick(); chk_ball("hb_t6", 5, 3);
        next_tick(); chk_ball("hb_t7", 4, 2);
        next_tick(); chk_ball("hb_t8", 3, 1);
        next_tick(); chk_ball("ha_hit", 2, 2);
        chk("ha_scoreB", scoreB, 0);
        btnB_r = 1'b0;

        // Reset mid-PLAY, then check the prescaler restarted from 0
        rst = 1'b1; step(); rst = 1'b0;
        chk_reset("rst_play");
        start = 1'b1; step(); start = 1'b0;
        repeat (10) step();
        chk_ball("pre_e11", 3, 3);
        step();
        chk_ball("pre_e12", 4, 4);
        next_tick(); chk_ball("pre_t2", 5, 5);
        rst = 1'b1; step(); rst = 1'b0;
        chk_reset("rst_55");
        repeat (8) step();
        chk_reset("rst_idle");

        // Paddle clamp on the SERVE_WAIT=8 instance
        start = 1'b1; step(); start = 1'b0;
        btnA_l = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_tick(); chk("clamp_padA", padA2, (i == 0) ? 2 : 1);
        end
        btnA_l = 1'b0; btnA_r = 1'b1;
        next_tick(); chk("clamp_right", padA2, 2);
        btnA_l = 1'b1;
        next_tick(); chk("clamp_both", padA2, 2);
        chk("clamp_playing", playing2, 1);
        chk("clamp_ballX", ballX2, 3);
        chk("clamp_ballY", ballY2, 3);
        btnA_l = 1'b0; btnA_r = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
